// File: rtl/ppu_vblank_write_queue.sv
// Holds CPU writes to PPU memories in a FIFO and releases them only while vblank
// is high so visible frames never tear; also raises a sticky frame interrupt on vblank rise.
module ppu_vblank_write_queue #(
    parameter int                DEPTH     = 16,
    parameter int                ADDR_W    = 12,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] CTRL_ADDR = 12'hFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_chipselect,
    input  logic              s_write,
    input  logic              s_read,
    input  logic [ADDR_W-1:0] s_address,
    input  logic [DATA_W-1:0] s_writedata,
    output logic [31:0]       s_readdata,
    output logic              s_waitrequest,
    input  logic              vblank,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_writedata,
    output logic              irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    logic [ADDR_W-1:0] fifo_addr_r [DEPTH];
    logic [DATA_W-1:0] fifo_data_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    state_t            state_r;
    logic              vblank_q_r;
    logic              irq_r;
    logic              m_chipselect_r;
    logic              m_write_r;
    logic [ADDR_W-1:0] m_address_r;
    logic [DATA_W-1:0] m_writedata_r;

    logic              data_wr_s;
    logic              ctrl_wr_s;
    logic              status_rd_s;
    logic              full_s;
    logic              push_s;
    logic              pop_s;
    logic [CNT_W-1:0]  count_next_s;
    logic              irq_set_s;
    logic              irq_clr_s;
    logic [31:0]       status_s;

    // Bus decode, push/pop qualification and next occupancy
    always_comb begin
        data_wr_s   = s_chipselect & s_write & (s_address != CTRL_ADDR);
        ctrl_wr_s   = s_chipselect & s_write & (s_address == CTRL_ADDR);
        status_rd_s = s_chipselect & s_read & (s_address == CTRL_ADDR);
        full_s      = (count_r == FULL_CNT);
        // A full queue stalls the writer even when a pop frees a slot this cycle.
        push_s      = data_wr_s & ~full_s;
        case (state_r)
            ST_IDLE:  pop_s = vblank & (count_r != ZERO_CNT);
            ST_DRAIN: pop_s = vblank & (count_r != ZERO_CNT);
            default:  pop_s = 1'b0;
        endcase
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + ONE_CNT;
            2'b01:   count_next_s = count_r - ONE_CNT;
            default: count_next_s = count_r;
        endcase
        irq_set_s = vblank & ~vblank_q_r;
        irq_clr_s = ctrl_wr_s & s_writedata[0];
    end

    // Zero-latency status port and write stall
    always_comb begin
        status_s = {irq_r, vblank, full_s, 13'b0, {(16 - CNT_W){1'b0}}, count_r};
        if (status_rd_s) begin
            s_readdata = status_s;
        end else begin
            s_readdata = 32'h0000_0000;
        end
        s_waitrequest = data_wr_s & full_s;
    end

    // Entry storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= s_address;
            fifo_data_r[wr_ptr_r] <= s_writedata;
        end
    end

    // Pointers, occupancy and drain FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= ZERO_CNT;
            state_r  <= ST_IDLE;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_PTR;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_PTR;
            end
            count_r <= count_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (vblank && (count_r != ZERO_CNT)) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!vblank || (count_next_s == ZERO_CNT)) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Registered PPU write port; address/data hold their last value between pops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_chipselect_r <= 1'b0;
            m_write_r      <= 1'b0;
            m_address_r    <= '0;
            m_writedata_r  <= '0;
        end else begin
            m_chipselect_r <= pop_s;
            m_write_r      <= pop_s;
            if (pop_s) begin
                m_address_r   <= fifo_addr_r[rd_ptr_r];
                m_writedata_r <= fifo_data_r[rd_ptr_r];
            end
        end
    end

    // Frame interrupt; vblank_q starts high so a vblank already active at reset is not an edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vblank_q_r <= 1'b1;
            irq_r      <= 1'b0;
        end else begin
            vblank_q_r <= vblank;
            if (irq_set_s) begin
                irq_r <= 1'b1;
            end else if (irq_clr_s) begin
                irq_r <= 1'b0;
            end
        end
    end

    assign m_chipselect = m_chipselect_r;
    assign m_write      = m_write_r;
    assign m_address    = m_address_r;
    assign m_writedata  = m_writedata_r;
    assign irq          = irq_r;

endmodule
